// File: rtl/spi_exec_pkg.sv
// Shared types and frame constants for the SPI execute-stage master.
// SPI_PARITY_EN appends an even-parity bit after the result.
package spi_exec_pkg;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

    localparam int unsigned CMD_BITS = 40;
    localparam int unsigned RSP_BITS = 16;
`ifdef SPI_PARITY_EN
    localparam int unsigned FRAME_BITS = CMD_BITS + RSP_BITS + 1;
`else
    localparam int unsigned FRAME_BITS = CMD_BITS + RSP_BITS;
`endif
    localparam int unsigned IDX_W = $clog2(FRAME_BITS + 1);

    localparam logic [IDX_W-1:0] CMD_IDX      = IDX_W'(CMD_BITS);
    localparam logic [IDX_W-1:0] LAST_CMD_IDX = IDX_W'(CMD_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FRAME_BITS - 1);

    localparam logic [7:0] OP_ALU_ADD = 8'h01;
    localparam logic [7:0] OP_ALU_SUB = 8'h02;
    localparam logic [7:0] OP_ALU_AND = 8'h03;
    localparam logic [7:0] OP_ALU_OR  = 8'h04;
    localparam logic [7:0] OP_ALU_XOR = 8'h05;
    localparam logic [7:0] OP_MUL_LO  = 8'h10;
    localparam logic [7:0] OP_MUL_HI  = 8'h11;
    localparam logic [7:0] OP_BAS_SLL = 8'h20;
    localparam logic [7:0] OP_BAS_SRL = 8'h21;
    localparam logic [7:0] OP_BAS_SRA = 8'h22;

endpackage

// File: rtl/spi_clk_div.sv
// sclk generator: toggles sclk every CLK_DIV enabled clocks and flags the
// clock before each rising/falling sclk edge with a one-cycle strobe.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             stb;

    assign stb      = enable && !clear && (cnt_q == CNT_MAX);
    assign rise_stb = stb && !sclk;
    assign fall_stb = stb && sclk;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (clear) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (enable) begin
            if (stb) begin
                cnt_q <= '0;
                sclk  <= ~sclk;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_exec_master.sv
// SPI master dispatching one {op, a, b} command frame and collecting a 16-bit
// result. Optional SPI_PARITY_EN checks an even-parity bit trailing the result.
module spi_exec_master
    import spi_exec_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned OP_W    = 8,
    parameter int unsigned DATA_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    state_e              state_q;
    logic [CMD_BITS-1:0] tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic [IDX_W-1:0]    idx_q;
    logic                accept;
    logic                rise_stb;
    logic                fall_stb;
`ifdef SPI_PARITY_EN
    logic                par_q;
`endif

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clock    (clock),
        .reset    (reset),
        .clear    (accept),
        .enable   (state_q == XFER),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            idx_q     <= '0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
`ifdef SPI_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        tx_q    <= {req_op, req_a, req_b};
                        mosi    <= req_op[OP_W-1];
                        cs_n    <= 1'b0;
                        idx_q   <= '0;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    // Result bits follow the command; the slave drives them MSB first.
                    if (rise_stb && idx_q >= CMD_IDX) begin
`ifdef SPI_PARITY_EN
                        if (idx_q == LAST_IDX) par_q <= miso;
                        else                   rx_q  <= {rx_q[DATA_W-2:0], miso};
`else
                        rx_q <= {rx_q[DATA_W-2:0], miso};
`endif
                    end
                    if (fall_stb) begin
                        tx_q  <= tx_q << 1;
                        mosi  <= (idx_q < LAST_CMD_IDX) ? tx_q[CMD_BITS-2] : 1'b0;
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == LAST_IDX) state_q <= DONE;
                    end
                end
                DONE: begin
                    cs_n      <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_data  <= rx_q;
`ifdef SPI_PARITY_EN
                    rsp_err   <= (^rx_q) != par_q;
`else
                    rsp_err   <= 1'b0;
`endif
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_exec_master.sv
// Bench for spi_exec_master: DUT 0 at CLK_DIV=4, DUT 1 at CLK_DIV=1, each with
// a mode-0 slave model; expected responses flow through a scoreboard queue.
module tb_spi_exec_master;

`ifdef SPI_PARITY_EN
    localparam int   FRAME_N = 57;
    localparam logic PAR     = 1'b1;
`else
    localparam int   FRAME_N = 56;
    localparam logic PAR     = 1'b0;
`endif

    typedef struct {
        int          u;
        logic [39:0] cmd;
        logic [15:0] data;
        logic        err;
        int          at;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [7:0]  req_op    [2];
    logic [15:0] req_a     [2];
    logic [15:0] req_b     [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_data  [2];
    logic        rsp_err   [2];
    logic        sclk      [2];
    logic        cs_n      [2];
    logic        mosi      [2];
    logic        miso      [2];

    logic [16:0] sl_next      [2];
    logic [16:0] sl_cur       [2];
    logic [39:0] sl_cmd       [2];
    int          sl_cnt       [2];
    int          sl_rises     [2];
    logic        sl_cs_prev   [2];
    logic        sl_sclk_prev [2];

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_exec_master #(
            .CLK_DIV ((g == 0) ? 4 : 1)
        ) dut (
            .clock     (clock),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_op    (req_op[g]),
            .req_a     (req_a[g]),
            .req_b     (req_b[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_data  (rsp_data[g]),
            .rsp_err   (rsp_err[g]),
            .sclk      (sclk[g]),
            .cs_n      (cs_n[g]),
            .mosi      (mosi[g]),
            .miso      (miso[g])
        );
    end

    // Mode-0 slave: captures the command on rising sclk, drives result bits after
    // each falling edge, then an even-parity bit (optionally inverted).
    always @(negedge clock) begin
        for (int u = 0; u < 2; u++) begin
            if (cs_n[u] !== 1'b0) begin
                sl_cnt[u] = 0;
                miso[u]   = 1'b0;
            end else begin
                if (sl_cs_prev[u] === 1'b1) begin
                    sl_cur[u]   = sl_next[u];
                    sl_cmd[u]   = '0;
                    sl_rises[u] = 0;
                end
                if (sclk[u] === 1'b1 && sl_sclk_prev[u] === 1'b0) begin
                    if (sl_cnt[u] < 40) sl_cmd[u] = {sl_cmd[u][38:0], mosi[u]};
                    sl_rises[u]++;
                end else if (sclk[u] === 1'b0 && sl_sclk_prev[u] === 1'b1) begin
                    sl_cnt[u]++;
                    if (sl_cnt[u] >= 40 && sl_cnt[u] < 56) miso[u] = sl_cur[u][55 - sl_cnt[u]];
                    else if (sl_cnt[u] == 56) miso[u] = (^sl_cur[u][15:0]) ^ sl_cur[u][16];
                    else miso[u] = 1'b0;
                end
            end
            sl_cs_prev[u]   = cs_n[u];
            sl_sclk_prev[u] = sclk[u];
        end
    end

    function automatic int lat(input int u);
        return 2 * FRAME_N * ((u == 0) ? 4 : 1) + 2;
    endfunction

    task automatic push_exp(input int u, input logic [7:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] data, input logic flip,
                            input int at);
        exp_t e;
        e.u = u; e.cmd = {op, a, b}; e.data = data; e.err = PAR & flip; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int u, input logic [7:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        req_op[u] = op; req_a[u] = a; req_b[u] = b; req_valid[u] = 1'b1;
    endtask

    task automatic wait_rsp(input int u);
        exp_t e;
        int   n = 0;
        e = exp_q.pop_front();
        while (rsp_valid[u] !== 1'b1 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (rsp_valid[u] !== 1'b1) begin
            $display("FAIL rsp_timeout u=%0d got no rsp_valid want one at cycle %0d", u, e.at);
            failures++;
        end else begin
            checks++;
            if (cyc !== e.at) begin
                $display("FAIL rsp_cycle u=%0d got %0d want %0d", u, cyc, e.at); failures++;
            end
            checks++;
            if (rsp_data[u] !== e.data) begin
                $display("FAIL rsp_data u=%0d got %h want %h", u, rsp_data[u], e.data);
                failures++;
            end
            checks++;
            if (rsp_err[u] !== e.err) begin
                $display("FAIL rsp_err u=%0d got %b want %b", u, rsp_err[u], e.err); failures++;
            end
            checks++;
            if (sl_cmd[u] !== e.cmd) begin
                $display("FAIL mosi_frame u=%0d got %h want %h", u, sl_cmd[u], e.cmd);
                failures++;
            end
            checks++;
            if (sl_rises[u] !== FRAME_N) begin
                $display("FAIL sclk_rises u=%0d got %0d want %0d", u, sl_rises[u], FRAME_N);
                failures++;
            end
            checks++;
            if (cs_n[u] !== 1'b1 || req_ready[u] !== 1'b1) begin
                $display("FAIL rsp_cs_ready u=%0d got cs_n=%b ready=%b want 1 1", u, cs_n[u],
                         req_ready[u]);
                failures++;
            end
            @(negedge clock);
            checks++;
            if (rsp_valid[u] !== 1'b0) begin
                $display("FAIL rsp_pulse u=%0d got %b want 0", u, rsp_valid[u]); failures++;
            end
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({req_ready[u], rsp_valid[u], rsp_data[u], rsp_err[u], sclk[u], cs_n[u],
                 mosi[u]} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                $display("FAIL reset_state u=%0d got %b%b_%h_%b%b%b%b want 10_0000_0010", u,
                         req_ready[u], rsp_valid[u], rsp_data[u], rsp_err[u], sclk[u],
                         cs_n[u], mosi[u]);
                failures++;
            end
        end
    endtask

    task automatic test_basic();
        @(posedge clock); #1;
        sl_next[0] = {1'b0, 16'hBEEF};
        push_exp(0, 8'h01, 16'h1234, 16'h00FF, 16'hBEEF, 1'b0, cyc + lat(0));
        drive(0, 8'h01, 16'h1234, 16'h00FF);
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        checks++;
        if (cs_n[0] !== 1'b0 || req_ready[0] !== 1'b0 || mosi[0] !== 1'b0) begin
            $display("FAIL accept got cs_n=%b ready=%b mosi=%b want 0 0 0", cs_n[0],
                     req_ready[0], mosi[0]);
            failures++;
        end
        wait_rsp(0);
    endtask

    task automatic test_busy_hold();
        int bad = 0;
        int extra = 0;
        @(posedge clock); #1;
        sl_next[0] = {1'b0, 16'h0F0F};
        push_exp(0, 8'h10, 16'hCAFE, 16'h0001, 16'h0F0F, 1'b0, cyc + lat(0));
        drive(0, 8'h10, 16'hCAFE, 16'h0001);
        @(posedge clock); #1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (i == 100) req_a[0] = 16'h5555;
            if (req_ready[0] !== 1'b0) bad++;
        end
        req_valid[0] = 1'b0;
        checks++;
        if (bad != 0) begin
            $display("FAIL busy_ready got %0d ready cycles want 0", bad); failures++;
        end
        wait_rsp(0);
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (rsp_valid[0] !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            $display("FAIL busy_extra_rsp got %0d want 0", extra); failures++;
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        @(posedge clock); #1;
        t0 = cyc;
        sl_next[0] = {1'b0, 16'h1357};
        push_exp(0, 8'h03, 16'hA5A5, 16'h5A5A, 16'h1357, 1'b0, t0 + lat(0));
        push_exp(0, 8'h02, 16'hFFFF, 16'h0002, 16'hFFFD, 1'b0, t0 + 2 * lat(0));
        drive(0, 8'h03, 16'hA5A5, 16'h5A5A);
        repeat (3) @(posedge clock);
        #1;
        sl_next[0] = {1'b0, 16'hFFFD};
        drive(0, 8'h02, 16'hFFFF, 16'h0002);
        wait_rsp(0);
        checks++;
        if (cs_n[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            $display("FAIL b2b_gap got cs_n=%b ready=%b want 0 0", cs_n[0], req_ready[0]);
            failures++;
        end
        req_valid[0] = 1'b0;
        wait_rsp(0);
    endtask

    task automatic test_reset_mid();
        int extra = 0;
        @(posedge clock); #1;
        sl_next[0] = {1'b0, 16'h7777};
        drive(0, 8'hFF, 16'hFFFF, 16'hFFFF);
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        repeat (199) @(posedge clock);
        #1;
        checks++;
        if (cs_n[0] !== 1'b0 || sclk[0] !== 1'b1 || mosi[0] !== 1'b1) begin
            $display("FAIL pre_abort got cs_n=%b sclk=%b mosi=%b want 0 1 1", cs_n[0], sclk[0],
                     mosi[0]);
            failures++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b0 || mosi[0] !== 1'b0) begin
            $display("FAIL abort_pins got cs_n=%b sclk=%b mosi=%b want 1 0 0", cs_n[0], sclk[0],
                     mosi[0]);
            failures++;
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (rsp_valid[0] !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            $display("FAIL abort_rsp got %0d want 0", extra); failures++;
        end
        @(posedge clock); #1;
        sl_next[0] = {1'b0, 16'h2468};
        push_exp(0, 8'h20, 16'h0F00, 16'h0004, 16'h2468, 1'b0, cyc + lat(0));
        drive(0, 8'h20, 16'h0F00, 16'h0004);
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        wait_rsp(0);
    endtask

    task automatic test_fast_div();
        int bad = 0;
        @(posedge clock); #1;
        sl_next[1] = {1'b0, 16'h8001};
        push_exp(1, 8'h04, 16'h0001, 16'h0002, 16'h8001, 1'b0, cyc + lat(1));
        drive(1, 8'h04, 16'h0001, 16'h0002);
        @(posedge clock); #1;
        req_valid[1] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (sclk[1] !== ((i % 2) == 0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL fast_sclk got %0d wrong cycles want 0", bad); failures++;
        end
        wait_rsp(1);
    endtask

    task automatic test_parity();
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            sl_next[0] = {(k == 0), 16'h0003};
            push_exp(0, 8'h05, 16'h0001, 16'h0002, 16'h0003, (k == 0), cyc + lat(0));
            drive(0, 8'h05, 16'h0001, 16'h0002);
            @(posedge clock); #1;
            req_valid[0] = 1'b0;
            wait_rsp(0);
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_op[u]    = '0;
            req_a[u]     = '0;
            req_b[u]     = '0;
            sl_next[u]   = '0;
        end
        repeat (2) @(negedge clock);
        test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        test_basic();
        test_busy_hold();
        test_back_to_back();
        test_reset_mid();
        test_fast_div();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
